// File: rtl/i2c_target_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_receiver_if
//  Description : Bus bundle for the I2C write-only target receiver: raw pad
//                inputs, open-drain SDA pull-down and received-byte status.
//  Revision    : 1.0  initial release
// ============================================================================
interface i2c_target_receiver_if;
    logic       Scl_In;
    logic       Sda_In;
    logic       Sda_Drive_Low_Out;
    logic [7:0] Rx_Data_Out;
    logic       Rx_Valid_Out;
    logic       Start_Det_Out;
    logic       Stop_Det_Out;
    logic       Busy_Out;

    // Bus-side driver: owns the pad levels, observes the target.
    modport master (
        output Scl_In, Sda_In,
        input  Sda_Drive_Low_Out, Rx_Data_Out, Rx_Valid_Out,
               Start_Det_Out, Stop_Det_Out, Busy_Out
    );

    // Target side: samples the pads, drives status and the SDA pull-down.
    modport slave (
        input  Scl_In, Sda_In,
        output Sda_Drive_Low_Out, Rx_Data_Out, Rx_Valid_Out,
               Start_Det_Out, Stop_Det_Out, Busy_Out
    );
endinterface
`default_nettype wire

// File: rtl/i2c_target_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target_receiver
//  Description : I2C target (write direction only). Synchronises SCL/SDA,
//                detects START/STOP, matches the 7-bit address, ACKs the
//                address and every data byte, and presents each received byte.
//  Option      : define I2C_GENERAL_CALL_EN to also ACK address 7'h00 (write).
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_target_receiver #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  wire logic            Clk_In,
    input  wire logic            Reset_N_In,
    i2c_target_receiver_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_DATA     = 3'd3,
        S_DATA_ACK = 3'd4,
        S_IGNORE   = 3'd5
    } state_t;

    // Synchroniser and edge-history flops; preset to the idle bus level (1).
    logic scl_meta_q, scl_sync_q, scl_prev_q;
    logic sda_meta_q, sda_sync_q, sda_prev_q;

    state_t     state_q,     state_d;
    logic [2:0] cnt_q,       cnt_d;
    logic [7:0] shift_q,     shift_d;
    logic [7:0] rx_data_q,   rx_data_d;
    logic       rx_valid_q,  rx_valid_d;
    logic       start_det_q, start_det_d;
    logic       stop_det_q,  stop_det_d;
    logic       drive_q,     drive_d;

    logic       scl_rise, scl_fall, start_evt, stop_evt, addr_hit;
    logic [7:0] shifted;

    // Two-stage synchronisers followed by one history flop per pin.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= bus.Scl_In;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= bus.Sda_In;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    // START/STOP need SCL stable high in both samples, so a simultaneous
    // SCL+SDA change is seen only as an SCL edge.
    assign scl_rise  =  scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q &  scl_prev_q;
    assign start_evt =  scl_sync_q &  scl_prev_q &  sda_prev_q & ~sda_sync_q;
    assign stop_evt  =  scl_sync_q &  scl_prev_q & ~sda_prev_q &  sda_sync_q;
    assign shifted   = {shift_q[6:0], sda_sync_q};

`ifdef I2C_GENERAL_CALL_EN
    assign addr_hit = ((shifted[7:1] == TARGET_ADDR) || (shifted[7:1] == 7'h00)) && !shifted[0];
`else
    assign addr_hit = (shifted[7:1] == TARGET_ADDR) && !shifted[0];
`endif

    // State and output registers; reset releases SDA asynchronously.
    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            drive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            drive_q     <= drive_d;
        end
    end

    // Next-state logic: STOP and START override whatever state we are in.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        drive_d     = drive_q;

        if (stop_evt) begin
            state_d    = S_IDLE;
            cnt_d      = 3'd0;
            drive_d    = 1'b0;
            stop_det_d = 1'b1;
        end else if (start_evt) begin
            state_d     = S_ADDR;
            cnt_d       = 3'd0;
            shift_d     = 8'h00;
            drive_d     = 1'b0;
            start_det_d = 1'b1;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7)
                            state_d = addr_hit ? S_ADDR_ACK : S_IGNORE;
                    end
                end
                // First SCL fall after bit 8 pulls SDA low for the ACK clock,
                // the next fall releases it and data reception begins.
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (scl_fall) begin
                        if (!drive_q) begin
                            drive_d = 1'b1;
                        end else begin
                            drive_d = 1'b0;
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (scl_rise) begin
                        shift_d = shifted;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_d  = shifted;
                            rx_valid_d = 1'b1;
                            state_d    = S_DATA_ACK;
                        end
                    end
                end
                S_IDLE, S_IGNORE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = S_IDLE;
                    drive_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.Sda_Drive_Low_Out = drive_q;
    assign bus.Rx_Data_Out       = rx_data_q;
    assign bus.Rx_Valid_Out      = rx_valid_q;
    assign bus.Start_Det_Out     = start_det_q;
    assign bus.Stop_Det_Out      = stop_det_q;
    assign bus.Busy_Out          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target_receiver
//  Description : Self-checking bench for i2c_target_receiver. A bit-level I2C
//                master drives the bus; expectations come from the I2C
//                addressing/ACK rules applied to the bytes sent.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_target_receiver;

    localparam logic [6:0] TGT = 7'h50;
    localparam int         Q   = 4;   // SCL-low setup/hold, in clk cycles
    localparam int         H   = 8;   // SCL-high time, in clk cycles
`ifdef I2C_GENERAL_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    int n_pass = 0;
    int n_total = 0;
    int n_start = 0, n_stop = 0, n_valid = 0, n_drive = 0;
    logic drive_prev = 1'b0;
    logic [7:0] model_rx = 8'h00;

    always #5 clk = ~clk;

    i2c_target_receiver_if u_if ();

    // Open-drain bus: the line is low if either side pulls it low.
    assign u_if.Scl_In = m_scl;
    assign u_if.Sda_In = m_sda & ~u_if.Sda_Drive_Low_Out;

    i2c_target_receiver #(.TARGET_ADDR(TGT)) u_dut (
        .Clk_In     (clk),
        .Reset_N_In (rst_n),
        .bus        (u_if.slave)
    );

    // Pulse and ACK-drive event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (u_if.Start_Det_Out) n_start++;
        if (u_if.Stop_Det_Out)  n_stop++;
        if (u_if.Rx_Valid_Out)  n_valid++;
        if (u_if.Sda_Drive_Low_Out && !drive_prev) n_drive++;
        drive_prev = u_if.Sda_Drive_Low_Out;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(H);
        m_sda = 1'b0; wait_cyc(H);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(H);
        m_sda = 1'b1; wait_cyc(H);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(H);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    // Eight data bits MSB first, then a ninth clock with SDA released;
    // ack=1 when the line is low in the middle of that clock.
    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(H / 2);
        ack = !u_if.Sda_In;
        wait_cyc(H / 2);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(6);
        model_rx = 8'h00;
        n_total++; if (u_if.Sda_Drive_Low_Out !== 1'b0) $display("FAIL reset_drive got=%b exp=0", u_if.Sda_Drive_Low_Out); else n_pass++;
        n_total++; if (u_if.Rx_Data_Out !== 8'h00) $display("FAIL reset_rx got=%h exp=00", u_if.Rx_Data_Out); else n_pass++;
        n_total++; if (u_if.Busy_Out !== 1'b0) $display("FAIL reset_busy got=%b exp=0", u_if.Busy_Out); else n_pass++;
        n_total++; if ({u_if.Rx_Valid_Out, u_if.Start_Det_Out, u_if.Stop_Det_Out} !== 3'b000)
            $display("FAIL reset_pulses got=%b exp=000", {u_if.Rx_Valid_Out, u_if.Start_Det_Out, u_if.Stop_Det_Out}); else n_pass++;
        n_total++; if (n_start !== 0) $display("FAIL reset_false_start got=%0d exp=0", n_start); else n_pass++;
    endtask

    // Pin edge at a negedge: clocked in by edge 1, pulse visible after edge 3.
    task automatic test_start_latency();
        logic [3:0] seen;
        m_sda = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            seen[i] = u_if.Start_Det_Out;
        end
        n_total++; if (seen !== 4'b0100) $display("FAIL start_latency got=%b exp=0100", seen); else n_pass++;
        n_total++; if (u_if.Busy_Out !== 1'b1) $display("FAIL start_busy got=%b exp=1", u_if.Busy_Out); else n_pass++;
        i2c_stop();
        n_total++; if (u_if.Busy_Out !== 1'b0) $display("FAIL stop_idle got=%b exp=0", u_if.Busy_Out); else n_pass++;
    endtask

    task automatic test_write_basic();
        int s0, p0, v0, d0;
        logic ack_a, ack_d;
        s0 = n_start; p0 = n_stop; v0 = n_valid; d0 = n_drive;
        i2c_start();
        send_byte({TGT, 1'b0}, ack_a);
        send_byte(8'hA5, ack_d);
        n_total++; if (u_if.Sda_Drive_Low_Out !== 1'b0) $display("FAIL basic_release got=%b exp=0", u_if.Sda_Drive_Low_Out); else n_pass++;
        i2c_stop();
        model_rx = 8'hA5;
        n_total++; if ({ack_a, ack_d} !== 2'b11) $display("FAIL basic_acks got=%b exp=11", {ack_a, ack_d}); else n_pass++;
        n_total++; if (n_drive - d0 != 2) $display("FAIL basic_ack_pulses got=%0d exp=2", n_drive - d0); else n_pass++;
        n_total++; if (n_valid - v0 != 1) $display("FAIL basic_valid got=%0d exp=1", n_valid - v0); else n_pass++;
        n_total++; if (u_if.Rx_Data_Out !== model_rx) $display("FAIL basic_rx got=%h exp=%h", u_if.Rx_Data_Out, model_rx); else n_pass++;
        n_total++; if (n_stop - p0 != 1) $display("FAIL basic_stop got=%0d exp=1", n_stop - p0); else n_pass++;
        n_total++; if (n_start - s0 != 1) $display("FAIL basic_start got=%0d exp=1", n_start - s0); else n_pass++;
        n_total++; if (u_if.Busy_Out !== 1'b0) $display("FAIL basic_busy got=%b exp=0", u_if.Busy_Out); else n_pass++;
    endtask

    task automatic test_addr_mismatch();
        int v0, d0;
        logic ack_a, ack_d;
        v0 = n_valid; d0 = n_drive;
        i2c_start();
        send_byte({7'h51, 1'b0}, ack_a);
        send_byte(8'h77, ack_d);
        n_total++; if (u_if.Busy_Out !== 1'b1) $display("FAIL mismatch_ignore_busy got=%b exp=1", u_if.Busy_Out); else n_pass++;
        i2c_stop();
        n_total++; if ({ack_a, ack_d} !== 2'b00) $display("FAIL mismatch_acks got=%b exp=00", {ack_a, ack_d}); else n_pass++;
        n_total++; if (n_drive - d0 != 0) $display("FAIL mismatch_drive got=%0d exp=0", n_drive - d0); else n_pass++;
        n_total++; if (n_valid - v0 != 0) $display("FAIL mismatch_valid got=%0d exp=0", n_valid - v0); else n_pass++;
        n_total++; if (u_if.Busy_Out !== 1'b0) $display("FAIL mismatch_stop_idle got=%b exp=0", u_if.Busy_Out); else n_pass++;
    endtask

    task automatic test_read_nack();
        int d0;
        logic ack_a;
        d0 = n_drive;
        i2c_start();
        send_byte({TGT, 1'b1}, ack_a);
        n_total++; if (ack_a !== 1'b0) $display("FAIL read_nack got=%b exp=0", ack_a); else n_pass++;
        n_total++; if (u_if.Busy_Out !== 1'b1) $display("FAIL read_ignore got=%b exp=1", u_if.Busy_Out); else n_pass++;
        n_total++; if (n_drive - d0 != 0) $display("FAIL read_drive got=%0d exp=0", n_drive - d0); else n_pass++;
        i2c_stop();
    endtask

    task automatic test_repeated_start();
        int s0, v0;
        logic a1, a2, a3;
        s0 = n_start; v0 = n_valid;
        i2c_start();
        send_byte({TGT, 1'b0}, a1);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
        i2c_start();
        send_byte({TGT, 1'b0}, a2);
        send_byte(8'h3C, a3);
        i2c_stop();
        model_rx = 8'h3C;
        n_total++; if ({a1, a2, a3} !== 3'b111) $display("FAIL rstart_acks got=%b exp=111", {a1, a2, a3}); else n_pass++;
        n_total++; if (n_start - s0 != 2) $display("FAIL rstart_starts got=%0d exp=2", n_start - s0); else n_pass++;
        n_total++; if (n_valid - v0 != 1) $display("FAIL rstart_valid got=%0d exp=1", n_valid - v0); else n_pass++;
        n_total++; if (u_if.Rx_Data_Out !== model_rx) $display("FAIL rstart_rx got=%h exp=%h", u_if.Rx_Data_Out, model_rx); else n_pass++;
    endtask

    task automatic test_general_call();
        int v0, d0;
        logic ack_a, ack_d;
        v0 = n_valid; d0 = n_drive;
        i2c_start();
        send_byte(8'h00, ack_a);
        send_byte(8'h5A, ack_d);
        i2c_stop();
        if (GC) model_rx = 8'h5A;
        n_total++; if (ack_a !== GC) $display("FAIL gcall_ack got=%b exp=%b", ack_a, GC); else n_pass++;
        n_total++; if (n_valid - v0 != (GC ? 1 : 0)) $display("FAIL gcall_valid got=%0d exp=%0d", n_valid - v0, GC ? 1 : 0); else n_pass++;
        n_total++; if (n_drive - d0 != (GC ? 2 : 0)) $display("FAIL gcall_drive got=%0d exp=%0d", n_drive - d0, GC ? 2 : 0); else n_pass++;
        n_total++; if (u_if.Rx_Data_Out !== model_rx) $display("FAIL gcall_rx got=%h exp=%h", u_if.Rx_Data_Out, model_rx); else n_pass++;
    endtask

    // Random transactions: address hit decides every ACK; a hit delivers each
    // complete data byte once; a trailing partial byte is always discarded.
    task automatic test_random();
        for (int t = 0; t < 16; t++) begin
            logic [6:0] addr;
            logic       rw, hit, ack;
            logic [7:0] data;
            int nb, nbits, s0, v0, d0;
            addr  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : TGT;
            rw    = ($urandom_range(0, 4) == 0);
            nb    = $urandom_range(0, 3);
            nbits = $urandom_range(0, 6);
            hit   = !rw && ((addr == TGT) || (GC && addr == 7'h00));
            s0 = n_start; v0 = n_valid; d0 = n_drive;
            i2c_start();
            send_byte({addr, rw}, ack);
            n_total++; if (ack !== hit) $display("FAIL rand_addr_ack t=%0d addr=%h rw=%b got=%b exp=%b", t, addr, rw, ack, hit); else n_pass++;
            for (int b = 0; b < nb; b++) begin
                data = 8'($urandom);
                send_byte(data, ack);
                if (hit) model_rx = data;
                n_total++; if (ack !== hit) $display("FAIL rand_data_ack t=%0d got=%b exp=%b", t, ack, hit); else n_pass++;
            end
            for (int k = 0; k < nbits; k++) send_bit(1'($urandom_range(0, 1)));
            if (t == 15 || $urandom_range(0, 1) == 1) i2c_stop();
            wait_cyc(2);
            n_total++; if (n_valid - v0 != (hit ? nb : 0)) $display("FAIL rand_valid t=%0d got=%0d exp=%0d", t, n_valid - v0, hit ? nb : 0); else n_pass++;
            n_total++; if (n_drive - d0 != (hit ? nb + 1 : 0)) $display("FAIL rand_drive t=%0d got=%0d exp=%0d", t, n_drive - d0, hit ? nb + 1 : 0); else n_pass++;
            n_total++; if (n_start - s0 != 1) $display("FAIL rand_start t=%0d got=%0d exp=1", t, n_start - s0); else n_pass++;
            n_total++; if (u_if.Rx_Data_Out !== model_rx) $display("FAIL rand_rx t=%0d got=%h exp=%h", t, u_if.Rx_Data_Out, model_rx); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_ack();
        int s0;
        logic ack_a;
        i2c_start();
        send_byte({TGT, 1'b0}, ack_a);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)));
        m_sda = 1'b1;
        for (int i = 0; i < 20 && !u_if.Sda_Drive_Low_Out; i++) @(negedge clk);
        n_total++; if (u_if.Sda_Drive_Low_Out !== 1'b1) $display("FAIL rst_ack_drive got=%b exp=1", u_if.Sda_Drive_Low_Out); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++; if (u_if.Sda_Drive_Low_Out !== 1'b0) $display("FAIL rst_async_release got=%b exp=0", u_if.Sda_Drive_Low_Out); else n_pass++;
        @(negedge clk);
        m_scl = 1'b1; m_sda = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        model_rx = 8'h00;
        s0 = n_start;
        wait_cyc(10);
        n_total++; if (u_if.Busy_Out !== 1'b0) $display("FAIL rst_idle got=%b exp=0", u_if.Busy_Out); else n_pass++;
        n_total++; if (n_start - s0 != 0) $display("FAIL rst_no_start got=%0d exp=0", n_start - s0); else n_pass++;
        n_total++; if (u_if.Rx_Data_Out !== model_rx) $display("FAIL rst_rx_clear got=%h exp=%h", u_if.Rx_Data_Out, model_rx); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_write_basic();
        test_addr_mismatch();
        test_read_nack();
        test_repeated_start();
        test_general_call();
        test_random();
        test_reset_mid_ack();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_target_receiver.md
I2C_TARGET_RECEIVER -- requirements
Module: I2C_Target_Receiver

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h50: 7-bit address this target answers.
REQ-002 SHALL have port Clk_In  input  1  system clock; all logic is on its rising edge.
REQ-003 SHALL have port Reset_N_In  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Scl_In  input  1  raw I2C SCL from the pad, asynchronous.
REQ-005 SHALL have port Sda_In  input  1  raw I2C SDA from the pad, asynchronous.
REQ-006 SHALL have port Sda_Drive_Low_Out  output  1  1 pulls SDA low (open-drain enable); 0 releases SDA.
REQ-007 SHALL have port Rx_Data_Out  output  8  last received data byte.
REQ-008 SHALL have port Rx_Valid_Out  output  1  one-cycle pulse when Rx_Data_Out updates.
REQ-009 SHALL have port Start_Det_Out  output  1  one-cycle pulse on START or repeated START.
REQ-010 SHALL have port Stop_Det_Out  output  1  one-cycle pulse on STOP.
REQ-011 SHALL have port Busy_Out  output  1  high while the state is not IDLE.

Function
REQ-012 SHALL pass Scl_In and Sda_In through 2-flop synchronizers, then one edge-history flop each.
REQ-013 SHALL detect START when synced SDA falls while synced SCL is high in both current and previous samples; STOP when synced SDA rises under the same SCL condition.
REQ-014 SHALL treat a sample where SCL and SDA both change as an SCL edge only; no START or STOP is flagged.
REQ-015 SHALL implement states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-016 SHALL transition from any state to ADDR on START, clearing the bit counter and shift register; a repeated START is handled identically.
REQ-017 SHALL transition from any state to IDLE on STOP and release SDA in the same cycle.
REQ-018 SHALL shift SDA into an 8-bit register, MSB first, on each synced SCL rising edge in ADDR and DATA; a 3-bit counter wraps 7->0.
REQ-019 SHALL handle the ADDR state on the 8th bit: if bits[7:1]==TARGET_ADDR and bit0==0 (write), go to ADDR_ACK; otherwise go to IGNORE.
REQ-020 SHALL, in ADDR_ACK and DATA_ACK, assert Sda_Drive_Low_Out on the first synced SCL falling edge after the 8th bit and release it on the next SCL falling edge, then enter DATA.
REQ-021 SHALL, on the 8th DATA bit, load Rx_Data_Out and pulse Rx_Valid_Out in the same cycle, then go to DATA_ACK.
REQ-022 SHALL, in IGNORE, never drive SDA and leave only on START or STOP.
REQ-023 SHALL produce Rx_Valid_Out, Start_Det_Out and Stop_Det_Out exactly 3 Clk_In cycles after the causing pin edge is first clocked (2 sync stages plus 1 output register).
REQ-024 SHALL hold Rx_Data_Out between Rx_Valid_Out pulses; a STOP or START mid-byte discards the partial byte with no pulse.
REQ-025 SHALL never assert Sda_Drive_Low_Out outside ADDR_ACK and DATA_ACK.

Reset
REQ-026 SHALL, while Reset_N_In is low, force state IDLE, counter 0, shift register 0, Rx_Data_Out 8'h00, and all 1-bit outputs 0.
REQ-027 SHALL preset synchronizer flops to 1, the idle bus level, so that no false START is seen after reset.
REQ-028 SHALL, if reset is asserted mid-ACK, release SDA immediately (asynchronously).

Configuration
REQ-029 SHALL, with macro I2C_GENERAL_CALL_EN defined, also ACK address 7'h00 with write, and treat the following bytes as DATA.
REQ-030 SHALL, without I2C_GENERAL_CALL_EN, handle address 7'h00 as a mismatch, go to IGNORE, and NACK it.

Verification
REQ-031 SHALL cover: START, addr 0x50+W, byte 0xA5, STOP -> two ACK low pulses; Rx_Data_Out=0xA5 with a single Rx_Valid_Out pulse; Stop_Det_Out pulse; Busy_Out low.
REQ-032 SHALL cover: START, addr 0x51+W -> SDA never driven; state IGNORE until STOP; no Rx_Valid_Out.
REQ-033 SHALL cover: START, addr 0x50+R -> NACK (SDA released on 9th clock); IGNORE.
REQ-034 SHALL cover: START, 0x50+W, 4 bits of data, repeated START, 0x50+W, 0x3C -> no pulse for the partial byte; Start_Det_Out pulses twice; Rx_Data_Out=0x3C.
REQ-035 SHALL cover: START, 0x00+W -> ACK with I2C_GENERAL_CALL_EN defined, NACK without it.
REQ-036 SHALL cover: reset asserted during DATA_ACK -> Sda_Drive_Low_Out=0 with no clock edge; after release, bus idle and state IDLE with no Start_Det_Out.
